// File: rtl/contador_pkg.sv
// Shared opcode and FSM state definitions for the contador controller.
package contador_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP          = 3'd0,
        OP_LOAD         = 3'd1,
        OP_SET_LIMIT    = 3'd2,
        OP_SET_PRESCALE = 3'd3,
        OP_START_UP     = 3'd4,
        OP_START_DOWN   = 3'd5,
        OP_STOP         = 3'd6,
        OP_CLEAR        = 3'd7
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_UP   = 2'd1,
        ST_RUN_DOWN = 2'd2
    } state_e;

endpackage

// File: rtl/contador_prescaler.sv
// Free-running divider: tick is high when the divider count equals prescale.
module contador_prescaler #(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q, cnt_d;

    // Step enable and wrap-to-zero next count.
    always_comb begin
        tick  = (cnt_q == prescale);
        cnt_d = tick ? '0 : cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end

    // Divider register; clr restarts the phase when a run starts.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/contador_ctrl.sv
// Command-driven sequencer for the contador counter: config, run FSM and count register.
module contador_ctrl
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] StepOne = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  periodic_q, periodic_d;
    logic                  reload_q, reload_d;   // next step reloads after a periodic terminal
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  busy_q;
    logic                  ready_q;

    cmd_op_e          op;
    logic             accept;
    logic             tick;
    logic             presc_clr;
    logic             cmd_wins;
    logic             step_up;
    logic [WIDTH-1:0] step_next;
    logic             step_term;

    assign op     = cmd_op_e'(cmd_op);
    assign accept = cmd_valid && ready_q;

    contador_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .clr      (presc_clr),
        .prescale (presc_q),
        .tick     (tick)
    );

    // Next-state, step arithmetic and command decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        limit_d    = limit_q;
        presc_d    = presc_q;
        periodic_d = periodic_q;
        reload_d   = reload_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        presc_clr  = 1'b0;
        cmd_wins   = 1'b0;

        step_up = (state_q == ST_RUN_UP);
        if (reload_q) begin
            step_next = step_up ? '0 : limit_q;
        end else begin
            step_next = step_up ? count_q + StepOne : count_q - StepOne;
        end
        // Compare against the pre-update limit so a same-cycle SET_LIMIT does not apply yet.
        step_term = step_up ? (step_next == limit_q) : (step_next == '0);

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_LOAD:         count_d = cmd_data;
                        OP_SET_LIMIT:    limit_d = cmd_data;
                        OP_SET_PRESCALE: presc_d = cmd_data[PRESCALE_W-1:0];
                        OP_START_UP, OP_START_DOWN: begin
                            periodic_d = cmd_data[0];
                            reload_d   = 1'b0;
                            presc_clr  = 1'b1;
                            state_d    = (op == OP_START_UP) ? ST_RUN_UP : ST_RUN_DOWN;
                        end
                        OP_CLEAR:        count_d = '0;
                        default: ;
                    endcase
                end
            end
            ST_RUN_UP, ST_RUN_DOWN: begin
                cmd_wins = accept && (op == OP_STOP || op == OP_CLEAR);
                if (tick && !cmd_wins) begin
                    count_d  = step_next;
                    reload_d = 1'b0;
                    if (step_term) begin
                        done_d = 1'b1;
                        if (periodic_q) begin
                            reload_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                if (accept) begin
                    case (op)
                        OP_SET_LIMIT:    limit_d = cmd_data;
                        OP_SET_PRESCALE: presc_d = cmd_data[PRESCALE_W-1:0];
                        OP_STOP: begin
                            state_d  = ST_IDLE;
                            reload_d = 1'b0;
                        end
                        OP_CLEAR: begin
                            state_d  = ST_IDLE;
                            count_d  = '0;
                            reload_d = 1'b0;
                        end
                        OP_LOAD, OP_START_UP, OP_START_DOWN: err_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            limit_q    <= '1;
            presc_q    <= '0;
            periodic_q <= 1'b0;
            reload_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            limit_q    <= limit_d;
            presc_q    <= presc_d;
            periodic_q <= periodic_d;
            reload_q   <= reload_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= (state_d != ST_IDLE);
            ready_q    <= 1'b1;
        end
    end

    assign cmd_ready = ready_q;
    assign count     = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Self-checking bench for contador_ctrl: directed scenarios plus randomized model comparison.
module tb_contador_ctrl;

    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, LIMIT = 3'd2, PRESC = 3'd3;
    localparam logic [2:0] UP = 3'd4, DOWN = 3'd5, STOP = 3'd6, CLEAR = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural reference: mode 0 idle, 1 counting up, 2 counting down.
    bit [7:0] m_count, m_limit, m_presc, m_div;
    bit       m_per, m_reload, m_done, m_err, m_ready;
    int       m_mode;

    contador_ctrl #(
        .WIDTH      (8),
        .PRESCALE_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic model_clock(input bit r, input bit v, input bit [2:0] op, input bit [7:0] d);
        bit       acc, tk, up, term, wins;
        bit [7:0] old_lim, nxt, ndiv;
        if (r) begin
            m_count = 8'h00; m_limit = 8'hFF; m_presc = 8'h00; m_div = 8'h00;
            m_per = 0; m_reload = 0; m_done = 0; m_err = 0; m_ready = 0; m_mode = 0;
            return;
        end
        acc     = v && m_ready;
        tk      = (m_div == m_presc);
        ndiv    = tk ? 8'd0 : m_div + 8'd1;
        old_lim = m_limit;
        m_done  = 0;
        m_err   = 0;
        if (m_mode == 0) begin
            if (acc) begin
                case (op)
                    LOAD:  m_count = d;
                    LIMIT: m_limit = d;
                    PRESC: m_presc = d;
                    UP, DOWN: begin
                        m_per = d[0]; m_reload = 0; ndiv = 8'd0;
                        m_mode = (op == UP) ? 1 : 2;
                    end
                    CLEAR: m_count = 8'h00;
                    default: ;
                endcase
            end
        end else begin
            up   = (m_mode == 1);
            wins = acc && (op == STOP || op == CLEAR);
            if (acc) begin
                case (op)
                    LIMIT: m_limit = d;
                    PRESC: m_presc = d;
                    STOP:  m_mode = 0;
                    CLEAR: begin m_mode = 0; m_count = 8'h00; end
                    LOAD, UP, DOWN: m_err = 1;
                    default: ;
                endcase
            end
            if (tk && !wins) begin
                if (m_reload) nxt = up ? 8'h00 : old_lim;
                else          nxt = up ? m_count + 8'd1 : m_count - 8'd1;
                term     = up ? (nxt == old_lim) : (nxt == 8'h00);
                m_count  = nxt;
                m_reload = 0;
                if (term) begin
                    m_done = 1;
                    if (m_per) m_reload = 1;
                    else       m_mode = 0;
                end
            end
        end
        m_div   = ndiv;
        m_ready = 1;
    endtask

    // Drive one cycle of inputs, advance the model, sample just after the edge.
    task automatic cyc(input bit r, input bit v, input bit [2:0] op, input bit [7:0] d);
        rst = r; cmd_valid = v; cmd_op = op; cmd_data = d;
        model_clock(r, v, op, d);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 0, NOP, 8'h00);
        cyc(1, 1, LOAD, 8'h33);
        n_checks++;
        if ({count, busy, done, err, cmd_ready} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_values: got count=%0h b=%0b d=%0b e=%0b r=%0b expected all 0",
                     count, busy, done, err, cmd_ready);
        end
        cyc(0, 0, NOP, 8'h00);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_after_reset: got %0b expected 1", cmd_ready);
        end
    endtask

    task automatic test_oneshot_up();
        bit [7:0] exp_c;
        cyc(0, 1, LOAD, 8'd5);
        cyc(0, 1, LIMIT, 8'd9);
        cyc(0, 1, PRESC, 8'd0);
        cyc(0, 1, UP, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(0, 0, NOP, 8'h00);
            exp_c = (i <= 4) ? 8'(5 + i) : 8'd9;
            n_checks++;
            if ({count, busy, done} !== {exp_c, (i < 4), (i == 4)}) begin
                n_errors++;
                $display("FAIL oneshot_up[%0d]: got count=%0d b=%0b d=%0b expected %0d %0b %0b",
                         i, count, busy, done, exp_c, (i < 4), (i == 4));
            end
        end
    endtask

    task automatic test_periodic_prescale();
        bit [7:0] seq [3] = '{8'd1, 8'd2, 8'd0};
        bit [7:0] exp_c;
        bit       exp_d;
        int       k;
        cyc(0, 1, PRESC, 8'd3);
        cyc(0, 1, LOAD, 8'd0);
        cyc(0, 1, LIMIT, 8'd2);
        cyc(0, 1, UP, 8'd1);
        for (int c = 1; c <= 20; c++) begin
            cyc(0, 0, NOP, 8'h00);
            k     = c / 4;
            exp_c = (k == 0) ? 8'd0 : seq[(k - 1) % 3];
            exp_d = (c % 4 == 0) && (exp_c == 8'd2);
            n_checks++;
            if ({count, busy, done} !== {exp_c, 1'b1, exp_d}) begin
                n_errors++;
                $display("FAIL periodic[%0d]: got count=%0d b=%0b d=%0b expected %0d 1 %0b",
                         c, count, busy, done, exp_c, exp_d);
            end
        end
        cyc(0, 1, STOP, 8'h00);
        for (int i = 0; i < 6; i++) cyc(0, 0, NOP, 8'h00);
        n_checks++;
        if ({count, busy, done} !== {8'd2, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL periodic_stop: got count=%0d b=%0b d=%0b expected 2 0 0",
                     count, busy, done);
        end
    endtask

    task automatic test_oneshot_down();
        cyc(0, 1, PRESC, 8'd0);
        cyc(0, 1, LOAD, 8'd3);
        cyc(0, 1, DOWN, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            cyc(0, 0, NOP, 8'h00);
            n_checks++;
            if ({count, busy, done} !== {8'(3 - i), (i < 3), (i == 3)}) begin
                n_errors++;
                $display("FAIL oneshot_down[%0d]: got count=%0d b=%0b d=%0b expected %0d %0b %0b",
                         i, count, busy, done, 3 - i, (i < 3), (i == 3));
            end
        end
    endtask

    task automatic test_err_and_clear();
        cyc(0, 1, LOAD, 8'h10);
        cyc(0, 1, LIMIT, 8'h80);
        cyc(0, 1, UP, 8'd0);
        cyc(0, 0, NOP, 8'h00);
        cyc(0, 1, LOAD, 8'h55);
        n_checks++;
        if ({count, busy, err} !== {8'h12, 1'b1, 1'b1}) begin
            n_errors++;
            $display("FAIL illegal_load: got count=%0h b=%0b e=%0b expected 12 1 1",
                     count, busy, err);
        end
        cyc(0, 0, NOP, 8'h00);
        n_checks++;
        if ({count, err} !== {8'h13, 1'b0}) begin
            n_errors++;
            $display("FAIL err_single_pulse: got count=%0h e=%0b expected 13 0", count, err);
        end
        cyc(0, 1, CLEAR, 8'h00);
        n_checks++;
        if ({count, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL clear_on_step: got count=%0h b=%0b d=%0b expected 0 0 0",
                     count, busy, done);
        end
    endtask

    task automatic test_full_wrap();
        cyc(0, 1, LOAD, 8'hFF);
        cyc(0, 1, LIMIT, 8'hFF);
        cyc(0, 1, UP, 8'd0);
        for (int i = 0; i < 256; i++) begin
            cyc(0, 0, NOP, 8'h00);
            n_checks++;
            if ({count, busy, done} !== {8'(i), (i < 255), (i == 255)}) begin
                n_errors++;
                $display("FAIL full_wrap[%0d]: got count=%0h b=%0b d=%0b expected %0h %0b %0b",
                         i, count, busy, done, i, (i < 255), (i == 255));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        cyc(0, 1, LOAD, 8'h30);
        cyc(0, 1, LIMIT, 8'hF0);
        cyc(0, 1, UP, 8'd0);
        for (int i = 0; i < 16; i++) cyc(0, 0, NOP, 8'h00);
        n_checks++;
        if ({count, busy} !== {8'h40, 1'b1}) begin
            n_errors++;
            $display("FAIL pre_reset: got count=%0h b=%0b expected 40 1", count, busy);
        end
        cyc(1, 0, NOP, 8'h00);
        n_checks++;
        if ({count, busy, done, err, cmd_ready} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_mid_run: got count=%0h b=%0b d=%0b e=%0b r=%0b expected all 0",
                     count, busy, done, err, cmd_ready);
        end
        cyc(0, 0, NOP, 8'h00);
        n_checks++;
        if ({count, busy, cmd_ready} !== {8'h00, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL release_mid_run: got count=%0h b=%0b r=%0b expected 0 0 1",
                     count, busy, cmd_ready);
        end
    endtask

    task automatic test_random();
        bit       r, v;
        bit [2:0] op;
        bit [7:0] d;
        cyc(1, 0, NOP, 8'h00);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 299) == 0);
            v  = ($urandom_range(0, 3) == 0);
            op = 3'($urandom_range(0, 7));
            d  = 8'($urandom);
            if (op == PRESC) d = d & 8'h03;
            if (op == LIMIT && d[7]) d = d & 8'h0F;
            cyc(r, v, op, d);
            n_checks++;
            if ({count, busy, done, err, cmd_ready} !==
                {m_count, (m_mode != 0), m_done, m_err, m_ready}) begin
                n_errors++;
                $display("FAIL random[%0d]: got c=%0h b=%0b d=%0b e=%0b r=%0b expected c=%0h b=%0b d=%0b e=%0b r=%0b",
                         i, count, busy, done, err, cmd_ready,
                         m_count, (m_mode != 0), m_done, m_err, m_ready);
            end
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = NOP; cmd_data = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_oneshot_up();
        test_periodic_prescale();
        test_oneshot_down();
        test_err_and_clear();
        test_full_wrap();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/contador_ctrl.md
Name: contador_ctrl

Overview:
- Command-driven controller that configures and sequences the contador counter datapath: start value, terminal limit, prescale rate, direction, and one-shot or periodic mode.
- Sits between the ui_in/uio_in decode logic and the counter register inside tt_um_contador.
- Produces the live count, a busy flag, a terminal-count pulse and an error pulse for uo_out/uio_out.

Parameters:
- WIDTH, 8, counter, limit and cmd_data width.
- PRESCALE_W, 8, prescale register width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command.
- cmd_op  input  3  opcode: 0 NOP, 1 LOAD, 2 SET_LIMIT, 3 SET_PRESCALE, 4 START_UP, 5 START_DOWN, 6 STOP, 7 CLEAR.
- cmd_data  input  WIDTH  operand; for START_* only bit 0 is used (1 = periodic).
- count  output  WIDTH  current counter value.
- busy  output  1  high in RUN_UP or RUN_DOWN.
- done  output  1  one-cycle pulse per terminal event.
- err  output  1  one-cycle pulse when a command is illegal in the current state.

Behaviour:
- Reset values: count=0, limit=all ones, prescale=0, periodic=0, state=IDLE, busy=0, done=0, err=0, cmd_ready=0.
  - cmd_ready rises the first cycle after rst drops and then stays 1.
  - Reset asserted mid-run returns everything to the reset values on the next edge.
- A command is accepted on the edge where cmd_valid && cmd_ready. Its effect is visible the following cycle. All outputs are registered.
- FSM states: IDLE, RUN_UP, RUN_DOWN.
- In IDLE:
  - LOAD: count<=cmd_data.
  - SET_LIMIT: limit<=cmd_data.
  - SET_PRESCALE: prescale<=cmd_data[PRESCALE_W-1:0].
  - START_UP / START_DOWN: periodic<=cmd_data[0], prescale counter cleared, state -> RUN_UP / RUN_DOWN.
  - STOP: no-op.
  - CLEAR: count<=0.
- In RUN_*:
  - SET_LIMIT and SET_PRESCALE take effect immediately.
  - STOP: state -> IDLE, count held.
  - CLEAR: state -> IDLE, count<=0.
  - LOAD or START_*: ignored, err pulses.
  - NOP: nothing.
- Prescaler: the step enable fires when the prescale counter equals prescale, and the counter then returns to 0. prescale=0 steps every cycle; prescale=N steps every N+1 cycles. The first step comes N+1 cycles after the START is accepted.
- Step arithmetic is modulo 2^WIDTH.
  - RUN_UP: next=count+1; terminal when next==limit.
  - RUN_DOWN: next=count-1; terminal when next==0.
  - Starting with count already at terminal runs a full wrap (2^WIDTH steps) before the terminal event.
- On a terminal step:
  - count<=next and done pulses on the next cycle.
  - Periodic: the run continues. The next step reloads 0 (up) or limit (down) instead of incrementing or decrementing.
  - One-shot: state -> IDLE, count holds the terminal value.
- Simultaneous events:
  - STOP or CLEAR accepted in the same cycle as a step: the command wins, no step and no done.
  - SET_LIMIT in the same cycle as a step: the terminal compare uses the old limit.
- The done and err pulses are never stretched. Back-to-back events give back-to-back pulses.

Decomposition:
- Package contador_pkg holds:
  - the cmd_op enum typedef (OP_NOP..OP_CLEAR);
  - the state enum (ST_IDLE, ST_RUN_UP, ST_RUN_DOWN);
  - localparam OP_W=3.
- One sub-module, contador_prescaler.
  - Ports: clk, rst, clr, prescale[PRESCALE_W-1:0], tick.
  - Function: the free-running divider that produces the step enable.
- FSM and count register stay in contador_ctrl.

Test Plan:
1. Reset, then LOAD 5, SET_LIMIT 9, prescale 0, START_UP data=0 -> count 6,7,8,9 on consecutive cycles. done pulses once, busy falls, count holds 9.
2. SET_PRESCALE 3, LOAD 0, SET_LIMIT 2, START_UP periodic -> a step every 4 cycles: 1,2(done),0,1,2(done). STOP -> busy=0, count frozen.
3. LOAD 3, START_DOWN one-shot, prescale 0 -> count 2,1,0. done with count=0, state IDLE.
4. During RUN_UP, issue LOAD 0x55 -> err pulse for 1 cycle, count unaffected. Then CLEAR on a step cycle -> count=0, no done, busy=0.
5. LOAD 0xFF, SET_LIMIT 0xFF, START_UP one-shot -> 256 steps: 0x00..0xFF, done at 0xFF.
6. Assert rst mid-run with count=0x40 -> all outputs at reset values next cycle. cmd_ready=0 during rst, 1 the cycle after release.
